dsi_stream_packer: RTL and testbench
====================================

# dsi_stream_packer

Parametrised byte-stream packer that repacks variable-size input groups (1..G_IN_BYTES bytes) into output words of a runtime-selectable width (1..G_OUT_BYTES bytes, the active DSI lane count). Both sides use valid/ready handshakes with full backpressure. Packet boundaries are explicit: a `last`-marked input beat is drained as a final, possibly partial, output word with byte enables. The block sits between the DSI packet assembler and the lane distributor.

## Interface
- G_IN_BYTES, 3, maximum bytes per input beat
- G_OUT_BYTES, 4, maximum bytes per output word
- G_BUF_BYTES, 2*max(G_IN_BYTES,G_OUT_BYTES)+2, internal buffer depth in bytes; must be ≥ G_IN_BYTES+G_OUT_BYTES
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- d_i  in  8*G_IN_BYTES  input bytes; first byte at d_i[8*d_size_i-1 -: 8], last byte at d_i[7:0]
- d_size_i  in  4  number of valid bytes in d_i, legal 1..G_IN_BYTES
- d_valid_i  in  1  input beat valid
- d_last_i  in  1  beat is the final beat of a packet
- d_ready_o  out  1  input beat accepted when d_valid_i && d_ready_o
- q_size_i  in  3  output word size, legal 1..G_OUT_BYTES; static while busy_o=1
- q_o  out  8*G_OUT_BYTES  output word; first byte at q_o[7:0]
- q_be_o  out  G_OUT_BYTES  per-byte valid; bit i covers q_o[8i+7:8i]
- q_last_o  out  1  final word of a packet
- q_valid_o  out  1  output word valid; held with stable q_o/q_be_o/q_last_o until q_ready_i
- q_ready_i  in  1  output word consumed when q_valid_o && q_ready_i
- busy_o  out  1  count≠0 or q_valid_o or DRAIN state
- err_o  out  1  one-cycle pulse: accepted beat had illegal d_size_i

## Operation
- Buffer: byte FIFO of G_BUF_BYTES, occupancy `count` (width clog2(G_BUF_BYTES+1)). Accepted beat appends d_size_i bytes in stream order.
- Output register: loaded from buffer head when (q_valid_o=0 or q_valid_o&&q_ready_i) and either count ≥ q_size_i, or state=DRAIN and count>0. Load takes n=min(count,q_size_i) bytes; q_be_o[i]=(i<n); bytes ≥n and lanes ≥q_size_i are driven 0.
- q_last_o=1 on the load that empties the buffer in DRAIN; exactly one q_last_o word per packet, also when the final word is full.
- States: FILL (reset) → DRAIN on accepted beat with d_last_i=1. DRAIN → FILL on handshake of the q_last_o word.
- d_ready_o = (state=FILL) && (G_BUF_BYTES − count ≥ G_IN_BYTES); registered-state function only, no combinational path from q_ready_i or d_valid_i.
- Illegal d_size_i (0 or >G_IN_BYTES): beat handshakes, no bytes stored, err_o pulses next cycle; d_last_i on such beat still enters DRAIN (if count=0 then return to FILL without emitting a word).
- Simultaneous accept and output load in one cycle: count_next = count + d_size_i − n.
- Changing q_size_i while busy_o=1 is a protocol violation; behaviour undefined.

## Timing
- Reset values: d_ready_o=1 (after first edge with rst_i=0 evaluated from count=0), q_valid_o=0, q_o=0, q_be_o=0, q_last_o=0, busy_o=0, err_o=0; count=0, state=FILL. rst_i mid-packet discards all buffered bytes and any pending output word.
- Latency: beat accepted at edge k → earliest q_valid_o high after edge k+1.
- Throughput: one output word per cycle while count ≥ q_size_i and q_ready_i=1; sustained input at one beat/cycle when G_IN_BYTES ≤ q_size_i and output not stalled.
- q_ready_i low: q_o/q_be_o/q_last_o/q_valid_o stable; input continues until buffer full, then d_ready_o=0.

## Test plan
- G_IN=3,G_OUT=4,q_size=4; beats {AA BB CC},{DD EE FF} with last on 2nd, q_ready=1 → word1 q_o=0xDDCCBBAA be=1111 last=0; word2 q_o=0x0000FFEE be=0011 last=1.
- q_size=2, six 1-byte beats 01..06, last on 06 → words 0x0201,0x0403,0x0605, only third has last=1, be=0011 each.
- q_size=4, beats of 3+1 bytes with last → single full word be=1111 last=1; busy_o low one cycle after handshake.
- q_ready_i held low 20 cycles with continuous 3-byte input → d_ready_o falls when free<3, q_o stable, no byte lost or duplicated after release (compare to scoreboard).
- Beat with d_size_i=0 then d_size_i=5 → both handshake, err_o pulses twice, count unchanged.
- rst_i asserted with 5 bytes buffered and q_valid_o=1 → next cycle q_valid_o=0, busy_o=0, d_ready_o=1; next packet emitted uncorrupted.

Source files
------------

// File: rtl/dsi_stream_packer.sv
// Byte-stream repacker: variable-size input beats (1..G_IN_BYTES) to output words of a
// runtime-selected width (1..G_OUT_BYTES), with explicit packet drain on 'last'.
module dsi_stream_packer #(
  parameter int G_IN_BYTES  = 3,
  parameter int G_OUT_BYTES = 4,
  parameter int G_BUF_BYTES = 2 * ((G_IN_BYTES > G_OUT_BYTES) ? G_IN_BYTES : G_OUT_BYTES) + 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [8*G_IN_BYTES-1:0]  d_i,
  input  logic [3:0]               d_size_i,
  input  logic                     d_valid_i,
  input  logic                     d_last_i,
  output logic                     d_ready_o,
  input  logic [2:0]               q_size_i,
  output logic [8*G_OUT_BYTES-1:0] q_o,
  output logic [G_OUT_BYTES-1:0]   q_be_o,
  output logic                     q_last_o,
  output logic                     q_valid_o,
  input  logic                     q_ready_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int CW    = $clog2(G_BUF_BYTES + 1);
  localparam int BUF_W = 8 * G_BUF_BYTES;

  typedef enum logic {
    ST_FILL,
    ST_DRAIN
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  // Byte 0 (bits 7:0) is the oldest byte in the buffer.
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic [8*G_OUT_BYTES-1:0] q_q, q_d;
  logic [G_OUT_BYTES-1:0]   be_q, be_d;
  logic                     last_q, last_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic [8*G_IN_BYTES-1:0]  in_ord;

  assign d_ready_o = (state_q == ST_FILL) &&
                     ((G_BUF_BYTES - int'(count_q)) >= G_IN_BYTES);
  assign busy_o    = (count_q != '0) || valid_q || (state_q == ST_DRAIN);
  assign q_o       = q_q;
  assign q_be_o    = be_q;
  assign q_last_o  = last_q;
  assign q_valid_o = valid_q;
  assign err_o     = err_q;

  always_comb begin
    int  cnt;
    int  out_size;
    int  in_size;
    int  add;
    int  take;
    logic size_ok;
    logic accept;
    logic out_free;
    logic load;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    buf_d   = buf_q;
    q_d     = q_q;
    be_d    = be_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    in_ord  = '0;

    cnt      = int'(count_q);
    in_size  = int'(d_size_i);
    out_size = int'(q_size_i);
    if (out_size < 1) begin
      out_size = 1;
    end else if (out_size > G_OUT_BYTES) begin
      out_size = G_OUT_BYTES;
    end

    size_ok  = (in_size >= 1) && (in_size <= G_IN_BYTES);
    accept   = d_valid_i && d_ready_o;
    out_free = !valid_q || q_ready_i;
    load     = out_free && ((cnt >= out_size) || ((state_q == ST_DRAIN) && (cnt > 0)));
    take     = load ? ((cnt < out_size) ? cnt : out_size) : 0;
    add      = (accept && size_ok) ? in_size : 0;

    // Reorder the beat so its first byte lands lowest, matching buffer order.
    for (int j = 0; j < G_IN_BYTES; j++) begin
      if (j < add) begin
        in_ord[8*j +: 8] = d_i[8*(add-1-j) +: 8];
      end
    end

    // Bytes beyond count are always zero, so the appended beat can simply be OR'ed in.
    buf_d   = (buf_q >> (8 * take)) | (BUF_W'(in_ord) << (8 * (cnt - take)));
    count_d = CW'(cnt + add - take);
    err_d   = accept && !size_ok;

    if (out_free) begin
      valid_d = 1'b0;
    end
    if (load) begin
      for (int i = 0; i < G_OUT_BYTES; i++) begin
        q_d[8*i +: 8] = (i < take) ? buf_q[8*i +: 8] : 8'h00;
        be_d[i]       = (i < take);
      end
      last_d  = (state_q == ST_DRAIN) && (take == cnt);
      valid_d = 1'b1;
    end

    case (state_q)
      ST_FILL: begin
        // An empty packet (only illegal beats) closes without emitting a word.
        if (accept && d_last_i) begin
          state_d = ((cnt + add - take) == 0) ? ST_FILL : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (valid_q && q_ready_i && last_q) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= ST_FILL;
      count_q <= '0;
      // NOTE: the byte buffer is reset on purpose: the append logic relies on every
      // byte beyond count being zero, so an unreset buffer would corrupt the stream.
      buf_q   <= '0;
      q_q     <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      q_q     <= q_d;
      be_q    <= be_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dsi_stream_packer.sv
// Self-checking bench for dsi_stream_packer: directed packets plus randomized traffic
// compared against a packet-chunking reference model.
module tb_dsi_stream_packer;

  localparam int GI = 3;
  localparam int GO = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [8*GI-1:0] d_i;
  logic [3:0]      d_size_i;
  logic            d_valid_i;
  logic            d_last_i;
  logic            d_ready_o;
  logic [2:0]      q_size_i;
  logic [8*GO-1:0] q_o;
  logic [GO-1:0]   q_be_o;
  logic            q_last_o;
  logic            q_valid_o;
  logic            q_ready_i;
  logic            busy_o;
  logic            err_o;

  always #5 clk_i = ~clk_i;

  dsi_stream_packer #(
    .G_IN_BYTES (GI),
    .G_OUT_BYTES(GO)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .d_i      (d_i),
    .d_size_i (d_size_i),
    .d_valid_i(d_valid_i),
    .d_last_i (d_last_i),
    .d_ready_o(d_ready_o),
    .q_size_i (q_size_i),
    .q_o      (q_o),
    .q_be_o   (q_be_o),
    .q_last_o (q_last_o),
    .q_valid_o(q_valid_o),
    .q_ready_i(q_ready_i),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  typedef struct {
    logic [8*GO-1:0] data;
    logic [GO-1:0]   be;
    logic            last;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] pkt_q[$];
  int         n_checks   = 0;
  int         n_errors   = 0;
  int         ready_mode = 0;  // 0: always ready, 1: stalled, 2: random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a packet's byte stream cut into q_size chunks, the final one marked last.
  function automatic void model_packet(input int qsz);
    word_t w;
    int    n;
    while (pkt_q.size() > 0) begin
      n      = (pkt_q.size() < qsz) ? pkt_q.size() : qsz;
      w.data = '0;
      w.be   = '0;
      for (int i = 0; i < n; i++) begin
        w.data[8*i +: 8] = pkt_q.pop_front();
        w.be[i]          = 1'b1;
      end
      w.last = (pkt_q.size() == 0);
      exp_q.push_back(w);
    end
  endfunction

  function automatic void expect_word(input logic [8*GO-1:0] data, input logic [GO-1:0] be,
                                      input logic last);
    word_t w;
    w.data = data;
    w.be   = be;
    w.last = last;
    exp_q.push_back(w);
  endfunction

  task automatic send_beat(input logic [8*GI-1:0] data, input int size, input bit last);
    int waited = 0;
    d_i       = data;
    d_size_i  = 4'(size);
    d_last_i  = last;
    d_valid_i = 1'b1;
    while (!d_ready_o && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    check("beat_accept_timeout", 64'(waited >= 200), 64'(0));
    @(posedge clk_i);
    #1;
    d_valid_i = 1'b0;
    d_last_i  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int waited = 0;
    while ((busy_o || exp_q.size() != 0) && waited < 500) begin
      @(negedge clk_i);
      waited++;
    end
    check(tag, 64'(waited >= 500), 64'(0));
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_packet();
    int              nb;
    int              sizes[5];
    logic [7:0]      bytes[$];
    logic [8*GI-1:0] data;
    int              qsz;
    qsz = int'(q_size_i);
    nb  = $urandom_range(1, 5);
    for (int b = 0; b < nb; b++) begin
      if (b < nb - 1 && $urandom_range(0, 9) == 0) begin
        sizes[b] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(4, 15);
      end else begin
        sizes[b] = $urandom_range(1, GI);
        for (int j = 0; j < sizes[b]; j++) bytes.push_back(8'($urandom));
      end
    end
    pkt_q = bytes;
    model_packet(qsz);
    for (int b = 0; b < nb; b++) begin
      if (sizes[b] >= 1 && sizes[b] <= GI) begin
        data = '0;
        for (int j = 0; j < sizes[b]; j++) data[8*(sizes[b]-1-j) +: 8] = bytes.pop_front();
      end else begin
        data = (8*GI)'($urandom);
      end
      send_beat(data, sizes[b], b == nb - 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  initial begin
    q_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       q_ready_i = 1'b1;
        1:       q_ready_i = 1'b0;
        default: q_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: scoreboard on every handshake, stability while stalled.
  word_t           mon_w;
  logic            stall_pending = 1'b0;
  logic [8*GO-1:0] held_q;
  logic [GO-1:0]   held_be;
  logic            held_last;

  always @(negedge clk_i) begin
    if (stall_pending && !rst_i) begin
      check("stall_valid", q_valid_o, 1'b1);
      check("stall_q", q_o, held_q);
      check("stall_be", q_be_o, held_be);
      check("stall_last", q_last_o, held_last);
    end
    stall_pending = q_valid_o && !q_ready_i && !rst_i;
    held_q        = q_o;
    held_be       = q_be_o;
    held_last     = q_last_o;
    if (q_valid_o && q_ready_i && !rst_i) begin
      if (exp_q.size() == 0) begin
        check("word_expected", 64'(exp_q.size()), 64'(1));
      end else begin
        mon_w = exp_q.pop_front();
        check("q_data", q_o, mon_w.data);
        check("q_be", q_be_o, mon_w.be);
        check("q_last", q_last_o, mon_w.last);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bp_bytes[$];
    logic [7:0] v;
    int         accepted;
    bit         saw_low;
    bit         hs;
    int         waited;

    rst_i     = 1'b1;
    d_i       = '0;
    d_size_i  = 4'd0;
    d_valid_i = 1'b0;
    d_last_i  = 1'b0;
    q_size_i  = 3'd4;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_d_ready", d_ready_o, 1'b1);
    check("rst_q_valid", q_valid_o, 1'b0);
    check("rst_q", q_o, '0);
    check("rst_be", q_be_o, '0);
    check("rst_last", q_last_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);

    // Two 3-byte beats into 4-byte words.
    expect_word(32'hDDCCBBAA, 4'b1111, 1'b0);
    expect_word(32'h0000FFEE, 4'b0011, 1'b1);
    send_beat(24'hAABBCC, 3, 1'b0);
    send_beat(24'hDDEEFF, 3, 1'b1);
    wait_idle("t1_idle");

    // Six single bytes into 2-byte words.
    q_size_i = 3'd2;
    expect_word(32'h00000201, 4'b0011, 1'b0);
    expect_word(32'h00000403, 4'b0011, 1'b0);
    expect_word(32'h00000605, 4'b0011, 1'b1);
    for (int k = 1; k <= 6; k++) send_beat(24'(k), 1, k == 6);
    wait_idle("t2_idle");

    // Exactly one full final word still carries last; busy drops right after it.
    q_size_i = 3'd4;
    expect_word(32'h44332211, 4'b1111, 1'b1);
    send_beat(24'h112233, 3, 1'b0);
    send_beat(24'h000044, 1, 1'b1);
    waited = 0;
    while (!(q_valid_o && q_ready_i && q_last_o) && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    check("t3_last_timeout", 64'(waited >= 50), 64'(0));
    @(negedge clk_i);
    check("t3_busy_low", busy_o, 1'b0);
    wait_idle("t3_idle");

    // Illegal sizes: handshake, pulse err, store nothing.
    send_beat(24'h123456, 0, 1'b0);
    @(negedge clk_i);
    check("err_size0", err_o, 1'b1);
    check("busy_size0", busy_o, 1'b0);
    @(negedge clk_i);
    check("err_single_cycle", err_o, 1'b0);
    send_beat(24'h654321, 5, 1'b0);
    @(negedge clk_i);
    check("err_size5", err_o, 1'b1);
    check("busy_size5", busy_o, 1'b0);
    send_beat(24'h000000, 0, 1'b1);
    @(negedge clk_i);
    check("err_empty_last", err_o, 1'b1);
    check("ready_empty_last", d_ready_o, 1'b1);
    check("busy_empty_last", busy_o, 1'b0);
    expect_word(32'h0000BEEF, 4'b0011, 1'b1);
    send_beat(24'h00EFBE, 2, 1'b1);
    wait_idle("t4_idle");

    // Output stalled while input streams 3-byte beats.
    ready_mode = 1;
    @(posedge clk_i);
    #1;
    accepted = 0;
    saw_low  = 1'b0;
    v        = 8'h40;
    d_i       = {v, v + 8'd1, v + 8'd2};
    d_size_i  = 4'd3;
    d_last_i  = 1'b0;
    d_valid_i = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      hs = d_ready_o;
      if (hs) begin
        bp_bytes.push_back(v);
        bp_bytes.push_back(v + 8'd1);
        bp_bytes.push_back(v + 8'd2);
        accepted += 3;
      end else begin
        saw_low = 1'b1;
      end
      @(posedge clk_i);
      #1;
      if (hs) begin
        v   = v + 8'd3;
        d_i = {v, v + 8'd1, v + 8'd2};
      end
    end
    d_valid_i = 1'b0;
    check("bp_ready_fell", 64'(saw_low), 64'(1));
    check("bp_accepted_bytes", 64'(accepted), 64'(12));
    bp_bytes.push_back(8'h77);
    pkt_q = bp_bytes;
    model_packet(4);
    ready_mode = 0;
    send_beat(24'h000077, 1, 1'b1);
    wait_idle("t5_idle");

    // Reset mid-packet with bytes buffered and a word pending.
    ready_mode = 1;
    @(posedge clk_i);
    #1;
    send_beat(24'h010203, 3, 1'b0);
    send_beat(24'h040506, 3, 1'b0);
    send_beat(24'h070809, 3, 1'b0);
    repeat (3) @(negedge clk_i);
    check("pre_rst_valid", q_valid_o, 1'b1);
    check("pre_rst_busy", busy_o, 1'b1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i      = 1'b0;
    ready_mode = 0;
    @(negedge clk_i);
    check("post_rst_valid", q_valid_o, 1'b0);
    check("post_rst_busy", busy_o, 1'b0);
    check("post_rst_ready", d_ready_o, 1'b1);
    expect_word(32'hDDCCBBAA, 4'b1111, 1'b0);
    expect_word(32'h0000FFEE, 4'b0011, 1'b1);
    send_beat(24'hAABBCC, 3, 1'b0);
    send_beat(24'hDDEEFF, 3, 1'b1);
    wait_idle("t6_idle");

    // Randomized packets, sizes and output backpressure.
    for (int p = 0; p < 60; p++) begin
      if (p % 5 == 0) begin
        wait_idle("rand_idle");
        q_size_i = 3'($urandom_range(1, GO));
      end
      ready_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      rand_packet();
    end
    ready_mode = 0;
    wait_idle("rand_final_idle");
    check("exp_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
